// File: rtl/MD_pkg.sv
// Shared widths, remote slot header layout and AXIS packing order for the remote position link.
package MD_pkg;

    localparam int unsigned OFFSET_WIDTH = 23;
    localparam int unsigned GCID_WIDTH   = 3;
    localparam int unsigned PID_WIDTH    = 9;
    localparam int unsigned ELEM_WIDTH   = 2;
    localparam int unsigned LIFE_WIDTH   = 4;
    localparam int unsigned DEST_WIDTH   = 4;

    localparam int unsigned GCID_BUS_W   = 3 * GCID_WIDTH;
    localparam int unsigned OFFSET_PKT_W = 3 * OFFSET_WIDTH + ELEM_WIDTH + PID_WIDTH;

    localparam int unsigned AXIS_DATA_W  = 512;
    localparam int unsigned SLOT_W       = 128;
    localparam int unsigned NUM_SLOTS    = 4;
    localparam int unsigned AXIS_W       = AXIS_DATA_W + DEST_WIDTH + 2;

    // Bit offsets inside one 128-bit slot
    localparam int unsigned SLOT_X_LSB    = 0;
    localparam int unsigned SLOT_Y_LSB    = 32;
    localparam int unsigned SLOT_Z_LSB    = 64;
    localparam int unsigned SLOT_LAST_BIT = 96;
    localparam int unsigned SLOT_LIFE_LSB = 97;
    localparam int unsigned SLOT_GCID_LSB = 101;
    localparam int unsigned SLOT_ELEM_LSB = 110;
    localparam int unsigned SLOT_PID_LSB  = 112;

    // AXIS bus order: {tlast, tvalid, tdest, tdata}
    localparam int unsigned AXIS_TDEST_LSB  = AXIS_DATA_W;
    localparam int unsigned AXIS_TVALID_BIT = AXIS_DATA_W + DEST_WIDTH;
    localparam int unsigned AXIS_TLAST_BIT  = AXIS_DATA_W + DEST_WIDTH + 1;

    localparam logic [AXIS_DATA_W-1:0] MARKER_DATA = AXIS_DATA_W'(1) << SLOT_LAST_BIT;

    typedef enum logic [0:0] {InIdle, InSlot} in_state_e;

    function automatic logic [SLOT_W-1:0] pack_slot(input logic [OFFSET_PKT_W-1:0] pkt,
                                                    input logic [GCID_BUS_W-1:0]   gcid,
                                                    input logic [LIFE_WIDTH-1:0]   life,
                                                    input logic                    last);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_X_LSB +: OFFSET_WIDTH]  = pkt[0 +: OFFSET_WIDTH];
        s[SLOT_Y_LSB +: OFFSET_WIDTH]  = pkt[OFFSET_WIDTH +: OFFSET_WIDTH];
        s[SLOT_Z_LSB +: OFFSET_WIDTH]  = pkt[2*OFFSET_WIDTH +: OFFSET_WIDTH];
        s[SLOT_LAST_BIT]               = last;
        s[SLOT_LIFE_LSB +: LIFE_WIDTH] = life;
        s[SLOT_GCID_LSB +: GCID_BUS_W] = gcid;
        s[SLOT_ELEM_LSB +: ELEM_WIDTH] = pkt[3*OFFSET_WIDTH +: ELEM_WIDTH];
        s[SLOT_PID_LSB +: PID_WIDTH]   = pkt[3*OFFSET_WIDTH+ELEM_WIDTH +: PID_WIDTH];
        return s;
    endfunction

    function automatic logic [AXIS_W-1:0] pack_axis(input logic                   last,
                                                    input logic                   valid,
                                                    input logic [DEST_WIDTH-1:0]  dest,
                                                    input logic [AXIS_DATA_W-1:0] data);
        return {last, valid, dest, data};
    endfunction

endpackage

// File: rtl/remote_pos_pack.sv
// Outbound packer: fills four slots per beat, flushes partial beats when the ring drains,
// and emits the once-per-iteration last-transfer marker beat.
module remote_pos_pack
    import MD_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEST_WIDTH-1:0]   dest_id_i,
    input  logic                    ring_empty_i,
    input  logic                    caches_dirty_i,
    input  logic                    iter_clear_i,
    input  logic [OFFSET_PKT_W-1:0] pkt_i,
    input  logic [GCID_BUS_W-1:0]   gcid_i,
    input  logic [LIFE_WIDTH-1:0]   life_i,
    input  logic                    pkt_valid_i,
    output logic [AXIS_W-1:0]       axis_o
);

    logic [AXIS_DATA_W-1:0] acc_q, acc_d, acc_w;
    logic [2:0]             fill_q, fill_d, fill_w;
    logic                   sent_q, sent_d;
    logic [AXIS_W-1:0]      axis_q, axis_d;

    always_comb begin
        acc_w  = acc_q;
        fill_w = fill_q;
        // A strobe lands in the current beat even when it also triggers a flush
        if (pkt_valid_i) begin
            acc_w[{fill_q[1:0], 7'd0} +: SLOT_W] = pack_slot(pkt_i, gcid_i, life_i, 1'b0);
            fill_w = fill_q + 3'd1;
        end
        acc_d  = acc_w;
        fill_d = fill_w;
        sent_d = sent_q;
        axis_d = '0;
        if (iter_clear_i) begin
            sent_d = 1'b0;
        end
        if (fill_w == 3'(NUM_SLOTS) || (ring_empty_i && fill_w != 3'd0)) begin
            axis_d = pack_axis(1'b0, 1'b1, dest_id_i, acc_w);
            acc_d  = '0;
            fill_d = '0;
        end else if (ring_empty_i && caches_dirty_i && !sent_q) begin
            axis_d = pack_axis(1'b1, 1'b1, dest_id_i, MARKER_DATA);
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            sent_q <= 1'b0;
            axis_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            sent_q <= sent_d;
            axis_q <= axis_d;
        end
    end

    assign axis_o = axis_q;

endmodule

// File: rtl/remote_pos_ctrl.sv
// Bridges the local position ring and the inter-FPGA AXI-Stream link (inbound unpack FSM here).
// Define REMOTE_POS_PERF_CNT_EN to add the o_beats_sent / o_beats_recv counters.
module remote_pos_ctrl
    import MD_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEST_WIDTH-1:0]   i_dest_id,
    input  logic                    i_all_pos_ring_nodes_empty,
    input  logic                    i_all_pos_caches_dirty,
    input  logic [OFFSET_PKT_W-1:0] i_offset_pkt_to_remote,
    input  logic [GCID_BUS_W-1:0]   i_gcid_to_remote,
    input  logic [LIFE_WIDTH-1:0]   i_lifetime_to_remote,
    input  logic                    i_offset_pkt_to_remote_valid,
    input  logic                    i_remote_ack_from_ring,
    input  logic [AXIS_DATA_W-1:0]  i_remote_tdata,
    input  logic                    i_remote_tvalid,
    output logic [OFFSET_PKT_W-1:0] o_remote_offset_pkt,
    output logic [GCID_BUS_W-1:0]   o_remote_gcid,
    output logic [LIFE_WIDTH-1:0]   o_remote_lifetime,
    output logic                    o_remote_valid,
    output logic                    o_last_transfer_from_remote,
    output logic                    o_remote_input_buf_ack,
`ifdef REMOTE_POS_PERF_CNT_EN
    output logic [31:0]             o_beats_sent,
    output logic [31:0]             o_beats_recv,
`endif
    output logic [AXIS_W-1:0]       o_axis_pos_pkt_to_remote
);

    in_state_e              state_q, state_d;
    logic [AXIS_DATA_W-1:0] word_q, word_d;
    logic [1:0]             idx_q, idx_d;
    logic                   pop_q, pop_d;
    logic                   flag_q, flag_d;
    logic                   dirty_q;
    logic                   iter_clear;
    logic [SLOT_W-1:0]      cur_slot;
    logic                   slot_valid, slot_done;
    logic                   unused_slot_bits;

    assign iter_clear = dirty_q & ~i_all_pos_caches_dirty;
    assign cur_slot   = word_q[{idx_q, 7'd0} +: SLOT_W];
    assign unused_slot_bits = ^{cur_slot[127:121], cur_slot[95:87], cur_slot[63:55],
                                cur_slot[31:23]};

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        pop_d      = 1'b0;
        flag_d     = flag_q;
        slot_valid = 1'b0;
        slot_done  = 1'b0;
        if (iter_clear) begin
            flag_d = 1'b0;
        end
        unique case (state_q)
            InIdle: begin
                // The popped word is still at the FIFO head during the pop cycle
                if (i_remote_tvalid && !pop_q) begin
                    word_d  = i_remote_tdata;
                    idx_d   = '0;
                    state_d = InSlot;
                end
            end
            InSlot: begin
                if (cur_slot[SLOT_LAST_BIT]) begin
                    flag_d    = 1'b1;
                    slot_done = 1'b1;
                end else if (cur_slot[SLOT_LIFE_LSB +: LIFE_WIDTH] == '0) begin
                    slot_done = 1'b1;
                end else begin
                    slot_valid = 1'b1;
                    slot_done  = i_remote_ack_from_ring;
                end
                if (slot_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = InIdle;
                        pop_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = InIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= InIdle;
            word_q  <= '0;
            idx_q   <= '0;
            pop_q   <= 1'b0;
            flag_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            pop_q   <= pop_d;
            flag_q  <= flag_d;
            dirty_q <= i_all_pos_caches_dirty;
        end
    end

    assign o_remote_valid              = slot_valid;
    assign o_remote_offset_pkt         = slot_valid ?
        {cur_slot[SLOT_PID_LSB +: PID_WIDTH], cur_slot[SLOT_ELEM_LSB +: ELEM_WIDTH],
         cur_slot[SLOT_Z_LSB +: OFFSET_WIDTH], cur_slot[SLOT_Y_LSB +: OFFSET_WIDTH],
         cur_slot[SLOT_X_LSB +: OFFSET_WIDTH]} : '0;
    assign o_remote_gcid               = slot_valid ? cur_slot[SLOT_GCID_LSB +: GCID_BUS_W] : '0;
    assign o_remote_lifetime           = slot_valid ? cur_slot[SLOT_LIFE_LSB +: LIFE_WIDTH] : '0;
    assign o_last_transfer_from_remote = flag_q;
    assign o_remote_input_buf_ack      = pop_q;

    remote_pos_pack u_pack (
        .clk            (clk),
        .rst            (rst),
        .dest_id_i      (i_dest_id),
        .ring_empty_i   (i_all_pos_ring_nodes_empty),
        .caches_dirty_i (i_all_pos_caches_dirty),
        .iter_clear_i   (iter_clear),
        .pkt_i          (i_offset_pkt_to_remote),
        .gcid_i         (i_gcid_to_remote),
        .life_i         (i_lifetime_to_remote),
        .pkt_valid_i    (i_offset_pkt_to_remote_valid),
        .axis_o         (o_axis_pos_pkt_to_remote)
    );

`ifdef REMOTE_POS_PERF_CNT_EN
    logic [31:0] sent_q, sent_d, recv_q, recv_d;

    always_comb begin
        sent_d = sent_q + {31'd0, o_axis_pos_pkt_to_remote[AXIS_TVALID_BIT]};
        recv_d = recv_q + {31'd0, pop_q};
        if (iter_clear) begin
            sent_d = '0;
            recv_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_q <= '0;
            recv_q <= '0;
        end else begin
            sent_q <= sent_d;
            recv_q <= recv_d;
        end
    end

    assign o_beats_sent = sent_q;
    assign o_beats_recv = recv_q;
`endif

endmodule

// File: tb/tb_remote_pos_ctrl.sv
// Self-checking bench for remote_pos_ctrl: directed scenarios plus randomized traffic
// scored against a slot-list / FIFO reference model.
module tb_remote_pos_ctrl;
    import MD_pkg::*;

    logic clk;
    logic rst;
    logic [DEST_WIDTH-1:0]   dest;
    logic                    ring_empty, dirty, strobe, ack, tvalid;
    logic [AXIS_DATA_W-1:0]  tdata;
    logic [22:0]             ob_x, ob_y, ob_z;
    logic [1:0]              ob_elem;
    logic [8:0]              ob_pid, ob_gcid;
    logic [3:0]              ob_life;
    logic [OFFSET_PKT_W-1:0] ob_pkt;
    logic [OFFSET_PKT_W-1:0] rv_pkt;
    logic [GCID_BUS_W-1:0]   rv_gcid;
    logic [LIFE_WIDTH-1:0]   rv_life;
    logic                    rv_valid, last_flag, pop;
    logic [AXIS_W-1:0]       axis;
`ifdef REMOTE_POS_PERF_CNT_EN
    logic [31:0]             beats_sent, beats_recv;
`endif

    assign ob_pkt = {ob_pid, ob_elem, ob_z, ob_y, ob_x};

    remote_pos_ctrl dut (
        .clk                          (clk),
        .rst                          (rst),
        .i_dest_id                    (dest),
        .i_all_pos_ring_nodes_empty   (ring_empty),
        .i_all_pos_caches_dirty       (dirty),
        .i_offset_pkt_to_remote       (ob_pkt),
        .i_gcid_to_remote             (ob_gcid),
        .i_lifetime_to_remote         (ob_life),
        .i_offset_pkt_to_remote_valid (strobe),
        .i_remote_ack_from_ring       (ack),
        .i_remote_tdata               (tdata),
        .i_remote_tvalid              (tvalid),
        .o_remote_offset_pkt          (rv_pkt),
        .o_remote_gcid                (rv_gcid),
        .o_remote_lifetime            (rv_life),
        .o_remote_valid               (rv_valid),
        .o_last_transfer_from_remote  (last_flag),
        .o_remote_input_buf_ack       (pop),
`ifdef REMOTE_POS_PERF_CNT_EN
        .o_beats_sent                 (beats_sent),
        .o_beats_recv                 (beats_recv),
`endif
        .o_axis_pos_pkt_to_remote     (axis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks, n_fail, n_valid, n_pops, n_words, n_beats, n_tlast;
    bit pop_pending;
    logic [AXIS_DATA_W-1:0] fifo[$];
    logic [92:0]            in_exp[$];
    logic [AXIS_DATA_W-1:0] wbuf;
    logic [AXIS_W-1:0]      exp_axis;
    logic [127:0]           mslot[4];
    int                     mcnt;
    bit                     msent, mdirty_prev;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_slot(input logic [31:0] x, y, z, input logic [3:0] life,
                                             input logic [8:0] gcid, input logic [1:0] elem,
                                             input logic [8:0] pid, input bit last);
        logic [31:0] hdr;
        hdr = (32'(pid) << 16) | (32'(elem) << 14) | (32'(gcid) << 5) | (32'(life) << 1)
            | 32'(last);
        return {hdr, z, y, x};
    endfunction

    task automatic put_slot(input int k, input logic [31:0] x, y, z, input logic [3:0] life,
                            input logic [8:0] gcid, input logic [1:0] elem, input logic [8:0] pid,
                            input bit last);
        wbuf[k*128 +: 128] = mk_slot(x, y, z, life, gcid, elem, pid, last);
        if (!last && life != 4'd0) in_exp.push_back({pid, elem, z[22:0], y[22:0], x[22:0], gcid, life});
    endtask

    task automatic commit_word();
        fifo.push_back(wbuf);
        n_words++;
    endtask

    task automatic rand_word(input bit live);
        for (int k = 0; k < 4; k++)
            put_slot(k, $urandom, $urandom, $urandom,
                     live ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15)),
                     9'($urandom), 2'($urandom), 9'($urandom), 1'b0);
        commit_word();
    endtask

    // Outbound reference: a list of pending slots, emitted on fill, drain or marker rules
    task automatic model_out();
        logic [AXIS_DATA_W-1:0] d;
        exp_axis = '0;
        if (strobe) begin
            mslot[mcnt] = mk_slot({9'd0, ob_x}, {9'd0, ob_y}, {9'd0, ob_z}, ob_life, ob_gcid,
                                  ob_elem, ob_pid, 1'b0);
            mcnt++;
        end
        if (mcnt == 4 || (ring_empty && mcnt > 0)) begin
            d = '0;
            for (int k = 0; k < mcnt; k++) d[k*128 +: 128] = mslot[k];
            exp_axis = {1'b0, 1'b1, dest, d};
            mcnt = 0;
        end else if (ring_empty && dirty && !msent) begin
            d = '0;
            d[96] = 1'b1;
            exp_axis = {1'b1, 1'b1, dest, d};
            msent = 1'b1;
        end
        if (mdirty_prev && !dirty) msent = 1'b0;
        mdirty_prev = dirty;
    endtask

    task automatic model_reset();
        exp_axis    = '0;
        mcnt        = 0;
        msent       = 1'b0;
        mdirty_prev = 1'b0;
        pop_pending = 1'b0;
    endtask

    task automatic tick();
        if (pop_pending) begin
            if (fifo.size() > 0) fifo.delete(0);
            pop_pending = 1'b0;
        end
        check("axis", axis, exp_axis);
        if (axis[AXIS_TVALID_BIT]) n_beats++;
        if (axis[AXIS_TLAST_BIT]) n_tlast++;
        if (rv_valid) begin
            n_valid++;
            if (in_exp.size() == 0) check("in_extra", rv_valid, 1'b0);
            else begin
                check("in_slot", {rv_pkt, rv_gcid, rv_life}, in_exp[0]);
                if (ack) in_exp.delete(0);
            end
        end
        if (pop) begin
            n_pops++;
            pop_pending = 1'b1;
        end
        tvalid = fifo.size() > 0;
        tdata  = tvalid ? fifo[0] : '0;
        model_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v0, p0, b0, l0, guard;
        n_checks = 0; n_fail = 0; n_valid = 0; n_pops = 0; n_words = 0; n_beats = 0; n_tlast = 0;
        rst = 1'b0; dest = '0; ring_empty = 0; dirty = 0; strobe = 0; ack = 0; tvalid = 0;
        tdata = '0; ob_x = '0; ob_y = '0; ob_z = '0; ob_elem = '0; ob_pid = '0; ob_gcid = '0;
        ob_life = '0; wbuf = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rv_valid, 1'b0);
        check("rst_pkt", rv_pkt, '0);
        check("rst_flag", last_flag, 1'b0);
        check("rst_pop", pop, 1'b0);
        check("rst_axis", axis, '0);
        rst = 1'b1;

        // Inbound word of four identical slots, ring acks at once
        ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wbuf[k*128 +: 128] = {32'h00015244, {3{32'hFFFFFFFF}}};
            in_exp.push_back({9'd1, 2'd1, {3{23'h7FFFFF}}, 9'h092, 4'd2});
        end
        v0 = n_valid; p0 = n_pops;
        commit_word();
        tick();
        check("in_latency", rv_valid, 1'b1);
        repeat (10) tick();
        check("in_valid_cnt", n_valid - v0, 4);
        check("in_pops", n_pops - p0, 1);
        check("in_drained", in_exp.size(), 0);

        // Same word with the ring stalled for ten cycles
        ack = 1'b0;
        for (int k = 0; k < 4; k++) in_exp.push_back({9'd1, 2'd1, {3{23'h7FFFFF}}, 9'h092, 4'd2});
        p0 = n_pops;
        commit_word();
        tick();
        repeat (10) begin
            check("hold_valid", rv_valid, 1'b1);
            check("hold_nopop", pop, 1'b0);
            tick();
        end
        ack = 1'b1;
        repeat (8) tick();
        check("hold_pops", n_pops - p0, 1);
        check("hold_drained", in_exp.size(), 0);

        // Four outbound strobes make one full beat
        dest = 4'd7; ob_x = 23'd1; ob_y = 23'd2; ob_z = 23'd3; ob_pid = 9'd1; ob_elem = 2'd1;
        ob_gcid = 9'd0; ob_life = 4'd4; strobe = 1'b1;
        repeat (4) tick();
        strobe = 1'b0;
        check("beat_tvalid", axis[AXIS_TVALID_BIT], 1'b1);
        check("beat_tlast", axis[AXIS_TLAST_BIT], 1'b0);
        check("beat_tdest", axis[AXIS_TDEST_LSB +: DEST_WIDTH], 4'd7);
        for (int k = 0; k < 4; k++) check("beat_hdr", axis[k*128+96 +: 32], 32'h00014008);
        tick();

        // One strobe, then drain: a flush beat, one marker beat, nothing more
        b0 = n_beats; l0 = n_tlast;
        ob_x = 23'($urandom); ob_pid = 9'($urandom); strobe = 1'b1;
        tick();
        strobe = 1'b0; ring_empty = 1'b1; dirty = 1'b1;
        repeat (6) tick();
        check("flush_beats", n_beats - b0, 2);
        check("marker_cnt", n_tlast - l0, 1);
        ring_empty = 1'b0; dirty = 1'b0;
        tick();

        // Inbound marker in slot 0 followed by three live slots
        dirty = 1'b1;
        put_slot(0, $urandom, $urandom, $urandom, 4'd5, 9'($urandom), 2'd0, 9'd3, 1'b1);
        for (int k = 1; k < 4; k++)
            put_slot(k, $urandom, $urandom, $urandom, 4'd3, 9'($urandom), 2'd2, 9'($urandom), 1'b0);
        v0 = n_valid;
        commit_word();
        repeat (10) tick();
        check("last_flag", last_flag, 1'b1);
        check("last_valid_cnt", n_valid - v0, 3);
        dirty = 1'b0;
        tick();
        check("last_clear", last_flag, 1'b0);

        // Reset while a slot is waiting for its ack
        ack = 1'b0;
        rand_word(1'b1);
        tick();
        tick();
        check("mid_valid", rv_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", rv_valid, 1'b0);
        check("mid_rst_pkt", rv_pkt, '0);
        check("mid_rst_pop", pop, 1'b0);
        check("mid_rst_axis", axis, '0);
        model_reset();
        tick();
        rst = 1'b1; ack = 1'b1;
        p0 = n_pops;
        repeat (10) tick();
        check("mid_pops", n_pops - p0, 1);
        check("mid_drained", in_exp.size(), 0);

        // Randomized traffic on both directions
        for (int c = 0; c < 800; c++) begin
            strobe     = $urandom_range(0, 9) < 4;
            ob_x       = 23'($urandom); ob_y = 23'($urandom); ob_z = 23'($urandom);
            ob_elem    = 2'($urandom); ob_pid = 9'($urandom); ob_gcid = 9'($urandom);
            ob_life    = 4'($urandom);
            ring_empty = $urandom_range(0, 9) == 0;
            dirty      = c[6];
            ack        = 1'($urandom);
            dest       = 4'($urandom);
            if (fifo.size() < 2 && $urandom_range(0, 3) == 0) rand_word(1'b0);
            tick();
        end
        strobe = 1'b0; ring_empty = 1'b1; dirty = 1'b0; ack = 1'b1;
        guard = 0;
        while ((fifo.size() > 0 || in_exp.size() > 0 || pop_pending) && guard < 300) begin
            tick();
            guard++;
        end
        tick();
        check("rand_fifo", fifo.size(), 0);
        check("rand_drained", in_exp.size(), 0);
        check("rand_pops", n_pops, n_words);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
